// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, ALU operation classes, FSM states and decoded
// instruction classes for the multi-cycle RV32 main control unit.
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_LUI    = 7'd55;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_RFN = 2;
    localparam int ALU_IFN = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_LOAD, C_STORE, C_BRANCH, C_IMM, C_LUI, C_NONE
    } cls_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier.
//   opcode in  7  instruction bits [6:0]
//   cls    out    instruction class (C_NONE when unsupported)
//   legal  out 1  opcode is supported by this build
// Build option: CTRL_IMM_ALU_EN adds OP-IMM and LUI to the supported set.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       legal
);
    cls_t base;

    assign base = opcode == OP_R      ? C_R      :
                  opcode == OP_LOAD   ? C_LOAD   :
                  opcode == OP_STORE  ? C_STORE  :
                  opcode == OP_BRANCH ? C_BRANCH : C_NONE;

`ifdef CTRL_IMM_ALU_EN
    assign cls = opcode == OP_IMM ? C_IMM :
                 opcode == OP_LUI ? C_LUI : base;
`else
    assign cls = base;
`endif

    assign legal = cls != C_NONE;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle main control FSM for the RV32 datapath.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   instr_valid/instr_ready    instruction handshake; ready only in IDLE
//   instruction                instruction word, latched into IR on accept
//   mem_ready                  data memory completes its access (MEM only)
//   branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, alu_op
//                              registered datapath controls per state
//   done, illegal, timeout     one-cycle status pulses
// Build option: CTRL_IMM_ALU_EN enables OP-IMM and LUI support.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ILEN        = 32,
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [ILEN-1:0]     instruction,
    input  logic                mem_ready,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                done,
    output logic                illegal,
    output logic                timeout
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    cls_t            cls_q;
    cls_t            dec_cls;
    logic            dec_legal;
    logic [ILEN-1:0] ir;
    logic [CW-1:0]   cnt;
    logic            done_q;
    logic            unused_ir;

    ctrl_decode u_decode (
        .opcode (ir[6:0]),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    assign unused_ir   = ^ir[ILEN-1:7];
    assign instr_ready = state == S_IDLE;
    // A store retires in the very cycle memory accepts it, so its done pulse
    // follows mem_ready directly while the registered mem_write is high.
    assign done = done_q | (mem_write & mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cls_q      <= C_NONE;
            ir         <= '0;
            cnt        <= '0;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= '0;
            done_q     <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            // Controls describe the state being entered; everything not
            // explicitly driven for that state drops to 0.
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= '0;
            done_q     <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir    <= instruction;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cls_q <= dec_cls;
                    if (!dec_legal) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state   <= S_EXEC;
                        alu_src <= dec_cls != C_R && dec_cls != C_BRANCH;
                        branch  <= dec_cls == C_BRANCH;
                        done_q  <= dec_cls == C_BRANCH;
                        alu_op  <= dec_cls == C_R      ? ALU_OP_W'(ALU_RFN) :
                                   dec_cls == C_BRANCH ? ALU_OP_W'(ALU_SUB) :
                                   dec_cls == C_IMM    ? ALU_OP_W'(ALU_IFN) :
                                                         ALU_OP_W'(ALU_ADD);
                    end
                end
                S_EXEC: begin
                    cnt <= '0;
                    if (cls_q == C_BRANCH) begin
                        state <= S_IDLE;
                    end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                        state      <= S_MEM;
                        mem_read   <= cls_q == C_LOAD;
                        mem_to_reg <= cls_q == C_LOAD;
                        mem_write  <= cls_q == C_STORE;
                        alu_src    <= 1'b1;
                    end else begin
                        state     <= S_WB;
                        reg_write <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                S_MEM: begin
                    // mem_ready takes priority over the timeout limit.
                    if (mem_ready) begin
                        if (cls_q == C_LOAD) begin
                            state      <= S_WB;
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                        state   <= S_TRAP;
                        timeout <= 1'b1;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        mem_read   <= cls_q == C_LOAD;
                        mem_to_reg <= cls_q == C_LOAD;
                        mem_write  <= cls_q == C_STORE;
                        alu_src    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench; a per-instruction
// schedule of expected outputs is built from the opcode and memory wait count.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        mem_ready = 1'b0;
    logic        instr_ready, branch, mem_read, mem_write, mem_to_reg;
    logic        alu_src, reg_write, done, illegal, timeout;
    logic [1:0]  alu_op;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .mem_ready   (mem_ready),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .done        (done),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] IDLE_V = 12'h800;
    localparam int LIMIT = 15;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_v = IDLE_V;
    logic        chk_on = 1'b0;
    string       tag = "reset";
    logic [11:0] sched[$];
    int          mplan[$];

    wire [11:0] act = {instr_ready, branch, mem_read, mem_write, mem_to_reg,
                       alu_src, reg_write, alu_op, done, illegal, timeout};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
        end
    endtask

    always @(negedge clk) if (chk_on) check(tag, {20'h0, act}, {20'h0, exp_v});

    function automatic logic [11:0] v(input bit br, mr, mw, m2r, as, rw,
                                      input logic [1:0] op, input bit dn, il, to);
        return {1'b0, br, mr, mw, m2r, as, rw, op, dn, il, to};
    endfunction

    // 0 R, 1 load, 2 store, 3 branch, 4 op-imm, 5 lui, 6 unsupported
    function automatic int kind(input logic [6:0] op);
        if (op == 7'd51) return 0;
        if (op == 7'd3)  return 1;
        if (op == 7'd35) return 2;
        if (op == 7'd99) return 3;
`ifdef CTRL_IMM_ALU_EN
        if (op == 7'd19) return 4;
        if (op == 7'd55) return 5;
`endif
        return 6;
    endfunction

    // Expected outputs for every cycle after accept until the return to IDLE.
    // w = MEM cycles without mem_ready before it arrives (>= LIMIT -> trap).
    task automatic build(input logic [31:0] ins, input int w);
        int k;
        logic [11:0] mv;
        k = kind(ins[6:0]);
        sched.delete();
        mplan.delete();
        sched.push_back('0); mplan.push_back(-1);
        case (k)
            0: begin
                sched.push_back(v(0,0,0,0,0,0,2'd2,0,0,0)); mplan.push_back(-1);
                sched.push_back(v(0,0,0,0,0,1,2'd0,1,0,0)); mplan.push_back(-1);
            end
            4, 5: begin
                sched.push_back(v(0,0,0,0,1,0,(k == 4) ? 2'd3 : 2'd0,0,0,0)); mplan.push_back(-1);
                sched.push_back(v(0,0,0,0,0,1,2'd0,1,0,0)); mplan.push_back(-1);
            end
            3: begin
                sched.push_back(v(1,0,0,0,0,0,2'd1,1,0,0)); mplan.push_back(-1);
            end
            1, 2: begin
                sched.push_back(v(0,0,0,0,1,0,2'd0,0,0,0)); mplan.push_back(-1);
                mv = (k == 1) ? v(0,1,0,1,1,0,2'd0,0,0,0) : v(0,0,1,0,1,0,2'd0,0,0,0);
                for (int i = 0; i < ((w < LIMIT) ? w : LIMIT); i++) begin
                    sched.push_back(mv); mplan.push_back(0);
                end
                if (w < LIMIT) begin
                    sched.push_back(mv | ((k == 2) ? 12'h004 : 12'h000)); mplan.push_back(1);
                    if (k == 1) begin
                        sched.push_back(v(0,0,0,1,0,1,2'd0,1,0,0)); mplan.push_back(-1);
                    end
                end else begin
                    sched.push_back(v(0,0,0,0,0,0,2'd0,0,0,1)); mplan.push_back(-1);
                end
            end
            default: begin
                sched.push_back(v(0,0,0,0,0,0,2'd0,0,1,0)); mplan.push_back(-1);
            end
        endcase
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE.
    // abort_at >= 0 applies reset that many cycles after accept instead of finishing.
    task automatic run(input logic [31:0] ins, input int w, input string name, input int abort_at);
        build(ins, w);
        tag = name;
        instr_valid = 1'b1;
        instruction = ins;
        mem_ready = 1'($urandom);
        exp_v = IDLE_V;
        foreach (sched[i]) begin
            @(posedge clk); #1;
            instr_valid = 1'($urandom);
            instruction = $urandom;
            mem_ready = (mplan[i] < 0) ? 1'($urandom) : 1'(mplan[i]);
            exp_v = sched[i];
            if (i + 1 == abort_at) begin
                #2;
                instr_valid = 1'b0;
                rst_n = 1'b0;
                exp_v = IDLE_V;
                #1;
                check({name, "_async"}, {20'h0, act}, {20'h0, IDLE_V});
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        mem_ready = 1'($urandom);
        exp_v = IDLE_V;
    endtask

    task automatic idle(input int n);
        tag = "idle";
        repeat (n) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            instruction = $urandom;
            mem_ready = 1'($urandom);
            exp_v = IDLE_V;
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  op;
        int          w;
        int          k;

        // Pin the model against hand-derived schedules.
        build(32'h002081B3, 0);
        check("model_add_len", sched.size(), 3);
        check("model_add_c2", {20'h0, sched[1]}, 32'h010);
        check("model_add_c3", {20'h0, sched[2]}, 32'h024);
        build(32'h00208463, 0);
        check("model_beq_c2", {20'h0, sched[1]}, 32'h40C);
        build(32'h0000007F, 0);
        check("model_ill_c2", {20'h0, sched[1]}, 32'h002);
        build(32'h0000A183, 2);
        check("model_lw_len", sched.size(), 6);
        check("model_lw_mem", {20'h0, sched[2]}, 32'h2C0);
        check("model_lw_wb", {20'h0, sched[5]}, 32'h0A4);
        build(32'h0030A023, 15);
        check("model_sw_to_len", sched.size(), 18);
        check("model_sw_to", {20'h0, sched[17]}, 32'h001);

        chk_on = 1'b1;
        exp_v = IDLE_V;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        run(32'h002081B3, 0, "add", -1);
        run(32'h0000A183, 2, "lw_wait", -1);
        idle(1);
        run(32'h0030A023, 15, "sw_timeout", -1);
        run(32'h0030A023, 14, "sw_ready_wins", -1);
        run(32'h0030A023, 0, "sw", -1);
        run(32'h00208463, 0, "beq", -1);
        run(32'h0000007F, 0, "illegal", -1);
        run(32'h00108093, 0, "addi", -1);
        run(32'h123450B7, 0, "lui", -1);
        run(32'h0000A183, 8, "lw_reset", 4);
        idle(3);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 6);
            op = (k == 0) ? 7'd51 : (k == 1) ? 7'd3 : (k == 2) ? 7'd35 :
                 (k == 3) ? 7'd99 : (k == 4) ? 7'd19 : (k == 5) ? 7'd55 : 7'($urandom);
            ins = $urandom;
            ins[6:0] = op;
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
            run(ins, w, "random", -1);
            idle($urandom_range(0, 2));
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
